// File: rtl/bcd_countdown_timer.sv
// bcd_countdown_timer
// -------------------
// Multi-digit BCD down-counter used for the voting-session timeout and the
// display countdown. A start value is loaded, then the count decrements by
// one for every TICK_DIV qualified tick strobes while running, and stops at
// zero (EXPIRED).
//
// Optional feature macro: BCD_TIMER_AUTORELOAD_EN
//   When defined, reaching zero reloads the stored start value and keeps
//   running (done_pulse still fires). A stored value of zero falls back to
//   the normal EXPIRED behaviour so the block cannot spin on a zero period.
//
// Parameters
//   DIGITS   : number of BCD digits (1..8), count width is 4*DIGITS
//   TICK_DIV : tick strobes per decrement (1..65535)
//
// Ports
//   clock      in   system clock, rising edge
//   reset      in   synchronous active-high reset
//   load       in   pulse, capture load_value (rejected if any nibble > 9)
//   load_value in   packed BCD start value, digit 0 in [3:0]
//   start      in   pulse, IDLE/PAUSED -> RUN
//   pause      in   pulse, RUN -> PAUSED
//   tick       in   time-base strobe, counted only in RUN
//   count      out  current BCD value (registered)
//   running    out  high while in RUN
//   expired    out  high while in EXPIRED
//   done_pulse out  one-cycle pulse when the count reaches zero
//   load_err   out  one-cycle pulse when a load is rejected
module bcd_countdown_timer #(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  input  logic                  start,
  input  logic                  pause,
  input  logic                  tick,
  output logic [4*DIGITS-1:0]   count,
  output logic                  running,
  output logic                  expired,
  output logic                  done_pulse,
  output logic                  load_err
);

  localparam int          W         = 4 * DIGITS;
  localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);
  localparam logic [W-1:0] ZERO     = {W{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_EXPIRED = 2'd3
  } state_t;

  // Digit-serial BCD decrement: a zero digit under borrow becomes 9 and
  // passes the borrow on, any other digit absorbs it.
  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] res;
    logic         borrow;
    logic [3:0]   d;
    res    = v;
    borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      d = v[4*i +: 4];
      if (borrow) begin
        if (d == 4'd0) begin
          res[4*i +: 4] = 4'd9;
          borrow        = 1'b1;
        end else begin
          res[4*i +: 4] = d - 4'd1;
          borrow        = 1'b0;
        end
      end else begin
        res[4*i +: 4] = d;
      end
    end
    return res;
  endfunction

  // True when every nibble is a legal BCD digit.
  function automatic logic bcd_valid(input logic [W-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) begin
        ok = 1'b0;
      end else begin
        ok = ok;
      end
    end
    return ok;
  endfunction

  state_t       state_q, state_d;
  logic [W-1:0] count_q, count_d;
  logic [15:0]  presc_q, presc_d;
  logic         running_q, running_d;
  logic         expired_q, expired_d;
  logic         done_q, done_d;
  logic         err_q, err_d;
  logic [W-1:0] dec_s;
`ifdef BCD_TIMER_AUTORELOAD_EN
  logic [W-1:0] reload_q, reload_d;
`endif

  assign dec_s = bcd_dec(count_q);

  // Next-state logic; event priority is load > pause > start > tick.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    presc_d  = presc_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
`ifdef BCD_TIMER_AUTORELOAD_EN
    reload_d = reload_q;
`endif
    if (load) begin
      if (bcd_valid(load_value)) begin
        count_d = load_value;
`ifdef BCD_TIMER_AUTORELOAD_EN
        reload_d = load_value;
`endif
        presc_d = 16'd0;
        state_d = ST_IDLE;
      end else begin
        err_d = 1'b1;
      end
    end else if (pause && (state_q == ST_RUN)) begin
      state_d = ST_PAUSED;
    end else if (start && ((state_q == ST_IDLE) || (state_q == ST_PAUSED))) begin
      // Starting from zero expires immediately; the coincident tick is dropped.
      if (count_q == ZERO) begin
        state_d = ST_EXPIRED;
        done_d  = 1'b1;
      end else begin
        state_d = ST_RUN;
      end
    end else if (tick && (state_q == ST_RUN)) begin
      if (presc_q >= TICK_LAST) begin
        presc_d = 16'd0;
        // Guard keeps the count from ever wrapping below zero.
        if (count_q != ZERO) begin
          count_d = dec_s;
          if (dec_s == ZERO) begin
            done_d = 1'b1;
`ifdef BCD_TIMER_AUTORELOAD_EN
            if (reload_q != ZERO) begin
              count_d = reload_q;
              state_d = ST_RUN;
            end else begin
              state_d = ST_EXPIRED;
            end
`else
            state_d = ST_EXPIRED;
`endif
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_EXPIRED;
        end
      end else begin
        presc_d = presc_q + 16'd1;
      end
    end else begin
      state_d = state_q;
    end

    running_d = (state_d == ST_RUN);
    expired_d = (state_d == ST_EXPIRED);
  end

  // State, count, prescaler and registered status outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      count_q   <= ZERO;
      presc_q   <= 16'd0;
      running_q <= 1'b0;
      expired_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef BCD_TIMER_AUTORELOAD_EN
      reload_q  <= ZERO;
`endif
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      presc_q   <= presc_d;
      running_q <= running_d;
      expired_q <= expired_d;
      done_q    <= done_d;
      err_q     <= err_d;
`ifdef BCD_TIMER_AUTORELOAD_EN
      reload_q  <= reload_d;
`endif
    end
  end

  assign count      = count_q;
  assign running    = running_q;
  assign expired    = expired_q;
  assign done_pulse = done_q;
  assign load_err   = err_q;

endmodule
